// File: rtl/nts_dispatch_pkg.sv
// Shared types and constants for the dispatch-buffer reader: FSM state encoding,
// accepted Ethertypes and the buffer word indices that hold the frame header.
package nts_dispatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_FETCH   = 3'd4,
        ST_LOAD    = 3'd5,
        ST_SEND    = 3'd6,
        ST_RELEASE = 3'd7
    } state_t;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_IPV6 = 16'h86DD;

    localparam int unsigned HDR0_WORD = 32'd0;
    localparam int unsigned HDR1_WORD = 32'd1;

    // Ethertype sits in bits [31:16] of header word 1.
    function automatic logic [15:0] ethertype_of(input logic [63:0] h1);
        return h1[31:16];
    endfunction

    function automatic logic ethertype_accepted(input logic [15:0] et);
        return (et == ETHERTYPE_IPV4) || (et == ETHERTYPE_IPV6);
    endfunction

endpackage

// File: rtl/nts_dispatcher_reader.sv
// Reads one complete frame out of the dispatch buffer and streams it downstream.
// Optional macro NTS_DISPATCHER_READER_ETHERTYPE_FILTER_EN drops short / non-IP frames.
module nts_dispatcher_reader
    import nts_dispatch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_dispatch_packet_available,
    input  logic [ADDR_WIDTH-1:0] i_dispatch_counter,
    input  logic [7:0]            i_dispatch_data_valid,
    output logic [ADDR_WIDTH-1:0] o_dispatch_raddr,
    input  logic [63:0]           i_dispatch_rdata,
    output logic                  o_dispatch_packet_read,
    output logic                  o_engine_valid,
    output logic [63:0]           o_engine_data,
    output logic                  o_engine_last,
    output logic [7:0]            o_engine_data_valid,
    input  logic                  i_engine_ready,
    output logic [31:0]           o_cnt_forwarded,
    output logic [31:0]           o_cnt_dropped
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_HDR0 = ADDR_WIDTH'(HDR0_WORD);
    localparam logic [ADDR_WIDTH-1:0] ADDR_HDR1 = ADDR_WIDTH'(HDR1_WORD);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]            mask_q, mask_d;
    logic [63:0]           h0_q, h0_d;
    logic [63:0]           h1_q, h1_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  pkt_read_q, pkt_read_d;
    logic                  ev_q, ev_d;
    logic [63:0]           ed_q, ed_d;
    logic                  el_q, el_d;
    logic [7:0]            edv_q, edv_d;
    logic                  hold_q, hold_d;
    logic                  dropping_q, dropping_d;
    logic [31:0]           cnt_fwd_q, cnt_fwd_d;
    logic                  drop_frame_s;
    logic                  drop_inc_s;

`ifdef NTS_DISPATCHER_READER_ETHERTYPE_FILTER_EN
    logic [31:0]           cnt_drop_q, cnt_drop_d;

    assign drop_frame_s = (cnt_q == ADDR_ZERO) || !ethertype_accepted(ethertype_of(h1_q));

    // Dropped-frame statistic, wraps modulo 2^32.
    always_comb begin
        if (drop_inc_s) begin
            cnt_drop_d = cnt_drop_q + 32'd1;
        end else begin
            cnt_drop_d = cnt_drop_q;
        end
    end

    // Dropped-frame statistic register.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            cnt_drop_q <= 32'd0;
        end else begin
            cnt_drop_q <= cnt_drop_d;
        end
    end

    assign o_cnt_dropped = cnt_drop_q;
`else
    assign drop_frame_s  = 1'b0;
    assign o_cnt_dropped = 32'd0;
`endif

    // Next-state and datapath decode for the read/forward sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        h0_d       = h0_q;
        h1_d       = h1_q;
        idx_d      = idx_q;
        raddr_d    = raddr_q;
        pkt_read_d = 1'b0;
        ev_d       = ev_q;
        ed_d       = ed_q;
        el_d       = el_q;
        edv_d      = edv_q;
        hold_d     = 1'b0;
        dropping_d = dropping_q;
        cnt_fwd_d  = cnt_fwd_q;
        drop_inc_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                raddr_d = ADDR_HDR0;
                // hold_q blocks the cycle right after a release, so a stale
                // packet_available cannot restart the frame just freed.
                if (i_dispatch_packet_available && !hold_q) begin
                    cnt_d   = i_dispatch_counter;
                    mask_d  = i_dispatch_data_valid;
                    raddr_d = ADDR_HDR1;
                    state_d = ST_HDR0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR0: begin
                h0_d = i_dispatch_rdata;
                if (cnt_q == ADDR_ZERO) begin
                    h1_d    = 64'd0;
                    state_d = ST_DECIDE;
                end else begin
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                h1_d    = i_dispatch_rdata;
                state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                idx_d = ADDR_ZERO;
                if (drop_frame_s) begin
                    dropping_d = 1'b1;
                    pkt_read_d = 1'b1;
                    state_d    = ST_RELEASE;
                end else begin
                    dropping_d = 1'b0;
                    ev_d       = 1'b1;
                    ed_d       = h0_q;
                    el_d       = (cnt_q == ADDR_ZERO);
                    edv_d      = (cnt_q == ADDR_ZERO) ? mask_q : 8'hFF;
                    state_d    = ST_SEND;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Word 1 is already held from the header read.
                ev_d    = 1'b1;
                ed_d    = (idx_q == ADDR_HDR1) ? h1_q : i_dispatch_rdata;
                el_d    = (idx_q == cnt_q);
                edv_d   = (idx_q == cnt_q) ? mask_q : 8'hFF;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (i_engine_ready) begin
                    ev_d = 1'b0;
                    if (el_q) begin
                        pkt_read_d = 1'b1;
                        state_d    = ST_RELEASE;
                    end else begin
                        idx_d   = idx_q + ADDR_ONE;
                        raddr_d = idx_q + ADDR_ONE;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_RELEASE: begin
                raddr_d = ADDR_ZERO;
                el_d    = 1'b0;
                edv_d   = 8'h00;
                ed_d    = 64'd0;
                hold_d  = 1'b1;
                if (dropping_q) begin
                    drop_inc_s = 1'b1;
                end else begin
                    cnt_fwd_d = cnt_fwd_q + 32'd1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= ADDR_ZERO;
            mask_q     <= 8'h00;
            h0_q       <= 64'd0;
            h1_q       <= 64'd0;
            idx_q      <= ADDR_ZERO;
            raddr_q    <= ADDR_ZERO;
            pkt_read_q <= 1'b0;
            ev_q       <= 1'b0;
            ed_q       <= 64'd0;
            el_q       <= 1'b0;
            edv_q      <= 8'h00;
            hold_q     <= 1'b0;
            dropping_q <= 1'b0;
            cnt_fwd_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            h0_q       <= h0_d;
            h1_q       <= h1_d;
            idx_q      <= idx_d;
            raddr_q    <= raddr_d;
            pkt_read_q <= pkt_read_d;
            ev_q       <= ev_d;
            ed_q       <= ed_d;
            el_q       <= el_d;
            edv_q      <= edv_d;
            hold_q     <= hold_d;
            dropping_q <= dropping_d;
            cnt_fwd_q  <= cnt_fwd_d;
        end
    end

    assign o_dispatch_raddr       = raddr_q;
    assign o_dispatch_packet_read = pkt_read_q;
    assign o_engine_valid         = ev_q;
    assign o_engine_data          = ed_q;
    assign o_engine_last          = el_q;
    assign o_engine_data_valid    = edv_q;
    assign o_cnt_forwarded        = cnt_fwd_q;

endmodule

// File: doc/nts_dispatcher_reader.md
NTS_DISPATCHER_READER -- requirements
Module: nts_dispatcher_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the dispatch buffer word-address width.
REQ-002 i_clk  in  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-003 i_areset  in  1  reset; asynchronous, active-high.
REQ-004 i_dispatch_packet_available  in  1  a complete good frame is held in the dispatch buffer.
REQ-005 i_dispatch_counter  in  ADDR_WIDTH  index of the frame's last word; frame length = counter+1 words.
REQ-006 i_dispatch_data_valid  in  8  byte-valid mask of the last word.
REQ-007 o_dispatch_raddr  out  ADDR_WIDTH  buffer read address.
REQ-008 i_dispatch_rdata  in  64  buffer read data, valid one cycle after o_dispatch_raddr; byte 0 in [63:56].
REQ-009 o_dispatch_packet_read  out  1  one-cycle pulse that releases the buffer.
REQ-010 o_engine_valid, o_engine_data[63:0], o_engine_last, o_engine_data_valid[7:0]  out  downstream word stream.
REQ-011 i_engine_ready  in  1  downstream accepts the word when valid&&ready.
REQ-012 o_cnt_forwarded[31:0], o_cnt_dropped[31:0]  out  frame statistics.

Function
REQ-013 FSM states: IDLE, HDR0, HDR1, DECIDE, FETCH, LOAD, SEND, RELEASE.
REQ-014 IDLE: when packet_available=1 the block SHALL latch counter and data_valid, drive raddr=0, and enter HDR0.
REQ-015 HDR0: the block SHALL capture rdata into header register H0 and drive raddr=1. HDR1: it SHALL capture H1.
REQ-016 If the latched counter is 0, HDR1 SHALL be skipped and H1 treated as all zero.
REQ-017 Ethertype SHALL be H1[31:16]. Accepted values: 16'h0800 and 16'h86DD.
REQ-018 DECIDE SHALL choose forward or drop (see REQ-027/028).
REQ-019 Forward: words 0 and 1 SHALL be sent from H0/H1. Words 2..counter SHALL then be sent via FETCH (drive raddr), LOAD (register rdata) and SEND.
REQ-020 Throughput SHALL be at most 1 word per 2 cycles. Words are sent strictly in address order with no gaps in word index.
REQ-021 SEND SHALL hold o_engine_valid=1 and keep data/last/data_valid stable until i_engine_ready=1.
REQ-022 o_engine_last=1 only on word index == counter; o_engine_data_valid=8'hFF on all other words and the latched mask on the last.
REQ-023 After the last word is accepted, or on a drop, the block SHALL enter RELEASE. RELEASE pulses o_dispatch_packet_read for exactly one cycle, increments the matching counter, and returns to IDLE.
REQ-024 packet_available still high in the cycle after RELEASE SHALL NOT start a new frame. The block waits one cycle in IDLE before resampling.
REQ-025 Changes to i_dispatch_counter while a frame is in progress SHALL be ignored; the latched value governs.
REQ-026 Statistics counters SHALL wrap modulo 2^32 without saturation.

Configuration
REQ-027 With NTS_DISPATCHER_READER_ETHERTYPE_FILTER_EN defined: frames with counter<1 or a non-accepted Ethertype SHALL be dropped without asserting o_engine_valid, and o_cnt_dropped SHALL be incremented.
REQ-028 Without the macro: every frame SHALL be forwarded, o_cnt_dropped SHALL be constant 0, and the HDR0/HDR1 capture is still used for words 0/1.

Reset
REQ-029 On i_areset: state=IDLE, and o_dispatch_raddr, o_dispatch_packet_read, o_engine_valid, o_engine_data, o_engine_last, o_engine_data_valid, o_cnt_forwarded and o_cnt_dropped SHALL all be 0, immediately and asynchronously.
REQ-030 Reset mid-frame SHALL abort the frame with no packet_read pulse and no counter change. After release the block restarts from IDLE.

Structure
REQ-031 A shared package nts_dispatch_pkg SHALL hold the FSM state typedef, ETHERTYPE_IPV4=16'h0800, ETHERTYPE_IPV6=16'h86DD, and the header word indices.
REQ-032 There are no sub-modules. The block SHALL be a single FSM with a datapath.

Verification
REQ-033 3-word frame (counter=2), Ethertype 0x0800, ready=1 -> 3 words out in order, last on word 2, one packet_read pulse, cnt_forwarded=1.
REQ-034 Same frame with ready low for 5 cycles on word 1 -> valid held, data stable for 5 cycles, no word lost or duplicated.
REQ-035 Ethertype 0x0806 with the filter macro -> no engine_valid, one packet_read pulse, cnt_dropped=1. Without the macro -> forwarded, cnt_forwarded=1.
REQ-036 Single-word frame (counter=0, data_valid=8'h0F) -> filter on: dropped. Filter off: one word with last=1 and data_valid=8'h0F.
REQ-037 Assert i_areset during word 2 of a 4-word frame -> all outputs 0 at once, no packet_read pulse. Re-presented frame is then fully forwarded.
REQ-038 Preload o_cnt_forwarded to 32'hFFFFFFFF and forward one frame -> counter wraps to 0.
